// File: rtl/imem_loader_pkg.sv
// Shared IMEM definitions: address width, fill instruction and loader FSM encoding.
package imem_loader_pkg;

    localparam int          IMEM_AW  = 10;
    localparam logic [31:0] NOP_INSN = 32'h00000013;  // addi x0,x0,0

    localparam logic [1:0] LOAD_LO = 2'd0;
    localparam logic [1:0] LOAD_HI = 2'd1;
    localparam logic [1:0] RUN     = 2'd2;

    function automatic logic [63:0] nop_pair(input logic [31:0] nop);
        return {nop, nop};
    endfunction

endpackage

// File: rtl/imem_loader_ram.sv
// DEPTH x W instruction RAM: one synchronous write port, one enabled synchronous read port, no reset.
module imem_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10,
    parameter int W     = 64
) (
    input  logic          clock_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rdata;

    always_ff @(posedge clock_i) begin
        if (we_i)
            r_mem[waddr_i] <= wdata_i;
        if (re_i)
            r_rdata <= r_mem[raddr_i];
    end

    assign rdata_o = r_rdata;

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction loader: packs 32-bit load words into 64-bit IMEM lines, then serves core fetches.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          DEPTH    = 1024,
    parameter logic [31:0] NOP_WORD = NOP_INSN
) (
    input  logic               clock_i,
    input  logic               reset_n_i,
    input  logic [IMEM_AW-1:0] addr_i,
    input  logic               fetch_en_i,
    output logic [63:0]        data_o,
    input  logic               ld_valid_i,
    input  logic [31:0]        ld_data_i,
    input  logic               ld_last_i,
    output logic               ld_ready_o,
    output logic               core_hold_o,
    output logic               err_o
);

    logic [1:0]         r_state;
    logic [IMEM_AW-1:0] r_wr_ptr;
    logic [31:0]        r_lo;
    logic               r_err;
    logic               r_out_ram;

    logic               w_ready;
    logic               w_acc;
    logic               w_we;
    logic               w_re;
    logic               w_at_end;
    logic [63:0]        w_wdata;
    logic [63:0]        w_rdata;

    assign w_ready  = (r_state != RUN);
    assign w_acc    = ld_valid_i && w_ready;
    assign w_at_end = (r_wr_ptr == IMEM_AW'(DEPTH - 1));
    // Once the last line has been written, every later word is swallowed without touching memory.
    assign w_we     = w_acc && !r_err &&
                      ((r_state == LOAD_HI) || (r_state == LOAD_LO && ld_last_i));
    assign w_wdata  = (r_state == LOAD_HI) ? {ld_data_i, r_lo} : {NOP_WORD, ld_data_i};
    assign w_re     = (r_state == RUN) && fetch_en_i;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state   <= LOAD_LO;
            r_wr_ptr  <= '0;
            r_lo      <= '0;
            r_err     <= 1'b0;
            r_out_ram <= 1'b0;
        end else begin
            if (w_acc) begin
                case (r_state)
                    LOAD_LO: begin
                        r_lo    <= ld_data_i;
                        r_state <= ld_last_i ? RUN : LOAD_HI;
                    end
                    LOAD_HI: r_state <= ld_last_i ? RUN : LOAD_LO;
                    default: r_state <= r_state;
                endcase
            end
            if (w_we) begin
                if (w_at_end)
                    r_err <= 1'b1;
                else
                    r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_re)
                r_out_ram <= 1'b1;
        end
    end

    imem_ram #(
        .DEPTH(DEPTH),
        .AW   (IMEM_AW),
        .W    (64)
    ) u_ram (
        .clock_i(clock_i),
        .we_i   (w_we),
        .waddr_i(r_wr_ptr),
        .wdata_i(w_wdata),
        .re_i   (w_re),
        .raddr_i(addr_i),
        .rdata_o(w_rdata)
    );

    // The RAM read register has no reset, so the NOP pair is presented until the first RUN fetch.
    assign data_o      = r_out_ram ? w_rdata : nop_pair(NOP_WORD);
    assign ld_ready_o  = w_ready;
    assign core_hold_o = w_ready;
    assign err_o       = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: load sequences, fetch vector table, reset and overflow corners.
module tb_imem_loader;

    localparam logic [31:0] NOP   = 32'h00000013;
    localparam logic [63:0] NOP2  = {NOP, NOP};

    logic        clock_i    = 1'b0;
    logic        reset_n_i  = 1'b0;
    logic [9:0]  addr_i     = '0;
    logic        fetch_en_i = 1'b0;
    logic [63:0] data_o;
    logic        ld_valid_i = 1'b0;
    logic [31:0] ld_data_i  = '0;
    logic        ld_last_i  = 1'b0;
    logic        ld_ready_o;
    logic        core_hold_o;
    logic        err_o;

    int n_total = 0;
    int n_pass  = 0;

    logic [63:0] q_exp[$];

    typedef struct {
        logic [9:0]  addr;
        logic        fe;
        logic [63:0] exp;
    } vec_t;

    vec_t vt[6];

    imem_loader dut (
        .clock_i    (clock_i),
        .reset_n_i  (reset_n_i),
        .addr_i     (addr_i),
        .fetch_en_i (fetch_en_i),
        .data_o     (data_o),
        .ld_valid_i (ld_valid_i),
        .ld_data_i  (ld_data_i),
        .ld_last_i  (ld_last_i),
        .ld_ready_o (ld_ready_o),
        .core_hold_o(core_hold_o),
        .err_o      (err_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic tick;
        @(posedge clock_i);
        #1;
    endtask

    task automatic chk64(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, got, exp);
    endtask

    task automatic chk1(input string nm, input logic got, input logic exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b want %b", nm, got, exp);
    endtask

    task automatic do_reset;
        ld_valid_i = 1'b0;
        fetch_en_i = 1'b0;
        reset_n_i  = 1'b0;
        tick();
        tick();
        reset_n_i  = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w, input logic last);
        int k;
        k = 0;
        while (!ld_ready_o && k < 20) begin
            tick();
            k++;
        end
        if (!ld_ready_o) begin
            n_total++;
            $display("FAIL ready_wait: got ld_ready_o=0 want 1 within 20 cycles");
        end
        ld_valid_i = 1'b1;
        ld_data_i  = w;
        ld_last_i  = last;
        tick();
        ld_valid_i = 1'b0;
        ld_last_i  = 1'b0;
    endtask

    // Expected line is queued as the fetch is driven and compared after the capturing edge.
    task automatic fetch(input string nm, input logic [9:0] a, input logic fe, input logic [63:0] exp);
        logic [63:0] e;
        addr_i     = a;
        fetch_en_i = fe;
        q_exp.push_back(exp);
        tick();
        fetch_en_i = 1'b0;
        e = q_exp.pop_front();
        chk64(nm, data_o, e);
    endtask

    function automatic logic [31:0] ow(input int i);
        return 32'hC0DE0000 + i;
    endfunction

    localparam logic [31:0] A0 = 32'h11110000, A1 = 32'h11110001, A2 = 32'h11110002, A3 = 32'h11110003;
    localparam logic [31:0] C0 = 32'h22220000, C1 = 32'h22220001, C2 = 32'h22220002;
    localparam logic [31:0] D0 = 32'h33330000, D1 = 32'h33330001, D2 = 32'h33330002;
    localparam logic [31:0] B0 = 32'h44440000, B1 = 32'h44440001;

    initial begin
        vt[0] = '{10'd0, 1'b1, {A1, A0}};
        vt[1] = '{10'd1, 1'b1, {A3, A2}};
        vt[2] = '{10'd0, 1'b0, {A3, A2}};
        vt[3] = '{10'd1, 1'b1, {A3, A2}};
        vt[4] = '{10'd0, 1'b1, {A1, A0}};
        vt[5] = '{10'd1, 1'b0, {A1, A0}};

        // Reset state
        do_reset();
        chk1 ("rst_ready", ld_ready_o, 1'b1);
        chk1 ("rst_hold",  core_hold_o, 1'b1);
        chk1 ("rst_err",   err_o, 1'b0);
        chk64("rst_data",  data_o, NOP2);

        // Even load A0..A3
        send_word(A0, 1'b0);
        send_word(A1, 1'b0);
        send_word(A2, 1'b0);
        chk1("hold_during_load", core_hold_o, 1'b1);
        send_word(A3, 1'b1);
        chk1 ("hold_falls", core_hold_o, 1'b0);
        chk1 ("run_ready",  ld_ready_o, 1'b0);
        chk64("run_nofetch_nop", data_o, NOP2);

        // Load traffic in RUN must be ignored
        ld_valid_i = 1'b1;
        ld_data_i  = 32'hDEADBEEF;
        ld_last_i  = 1'b1;
        #1;
        chk1("run_valid_ready", ld_ready_o, 1'b0);
        repeat (3) tick();
        ld_valid_i = 1'b0;
        ld_last_i  = 1'b0;
        chk1("run_valid_hold", core_hold_o, 1'b0);

        for (int i = 0; i < 6; i++)
            fetch($sformatf("vec%0d", i), vt[i].addr, vt[i].fe, vt[i].exp);

        // Odd load: last word lands in the low half with a NOP above it
        do_reset();
        send_word(C0, 1'b0);
        send_word(C1, 1'b0);
        send_word(C2, 1'b1);
        chk1("odd_hold", core_hold_o, 1'b0);
        fetch("odd_line1", 10'd1, 1'b1, {NOP, C2});
        fetch("odd_line0", 10'd0, 1'b1, {C1, C0});

        // Asynchronous reset while RUN data is on the output
        reset_n_i = 1'b0;
        #1;
        chk64("async_rst_data_run", data_o, NOP2);
        chk1 ("async_rst_hold_run", core_hold_o, 1'b1);
        tick();
        reset_n_i = 1'b1;

        // Reset mid-load, then reload from line 0
        send_word(D0, 1'b0);
        send_word(D1, 1'b0);
        send_word(D2, 1'b0);
        reset_n_i = 1'b0;
        #1;
        chk64("async_rst_data", data_o, NOP2);
        chk1 ("async_rst_ready", ld_ready_o, 1'b1);
        tick();
        reset_n_i = 1'b1;
        send_word(B0, 1'b0);
        send_word(B1, 1'b1);
        fetch("reload_line0", 10'd0, 1'b1, {B1, B0});
        fetch("reload_line1_kept", 10'd1, 1'b1, {NOP, C2});

        // Overflow: 2050 words fill 1024 lines and spill one extra line
        do_reset();
        for (int i = 0; i < 2050; i++) begin
            send_word(ow(i), (i == 2049));
            if (i == 2045) chk1("ovf_err_before", err_o, 1'b0);
            if (i == 2047) chk1("ovf_err_set", err_o, 1'b1);
            if (i == 2048) chk1("ovf_still_loading", ld_ready_o, 1'b1);
        end
        chk1("ovf_err_sticky", err_o, 1'b1);
        chk1("ovf_run_hold",   core_hold_o, 1'b0);
        chk1("ovf_run_ready",  ld_ready_o, 1'b0);
        fetch("ovf_line1023", 10'd1023, 1'b1, {ow(2047), ow(2046)});
        fetch("ovf_line0",    10'd0,    1'b1, {ow(1), ow(0)});
        fetch("ovf_line512",  10'd512,  1'b1, {ow(1025), ow(1024)});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
